// File: rtl/dpram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpram_pkg
// Description : Shared widths and client-select encoding for the dual-client
//               RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dpram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    // Client select: which requester owns a port or a returning read
    typedef enum logic {
        CLI_A = 1'b0,
        CLI_B = 1'b1
    } cli_t;

endpackage : dpram_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-client round-robin arbiter. Grant is combinational from
//               the requests and a registered priority pointer; the pointer
//               moves past the granted client only when advance is high.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dpram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,      // bit 0 = client A, bit 1 = client B
    input  logic       advance,  // a transfer happened on the current grant
    output logic [1:0] gnt
);

    cli_t r_prio;

    // Lone requester always wins; on contention the favoured client wins
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (r_prio == CLI_A) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Favour the other client after a completed transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= CLI_A;
        end else if (advance) begin
            r_prio <= gnt[0] ? CLI_B : CLI_A;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dpram_port_arbiter
// Description : Arbitrates two clients (A, B) onto the write port and the read
//               port of an external simple dual-port RAM. Each port has its
//               own round-robin; reads colliding with a same-cycle write to
//               the same address are stalled one cycle so they see new data.
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_port_arbiter
    import dpram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    // write clients
    input  logic              a_wr_req,
    input  logic [ADDR_W-1:0] a_wr_addr,
    input  logic [DATA_W-1:0] a_wr_data,
    output logic              a_wr_gnt,
    input  logic              b_wr_req,
    input  logic [ADDR_W-1:0] b_wr_addr,
    input  logic [DATA_W-1:0] b_wr_data,
    output logic              b_wr_gnt,
    // read clients
    input  logic              a_rd_req,
    input  logic [ADDR_W-1:0] a_rd_addr,
    output logic              a_rd_gnt,
    output logic              a_rd_valid,
    output logic [DATA_W-1:0] a_rd_data,
    input  logic              b_rd_req,
    input  logic [ADDR_W-1:0] b_rd_addr,
    output logic              b_rd_gnt,
    output logic              b_rd_valid,
    output logic [DATA_W-1:0] b_rd_data,
    // RAM side
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [1:0]        w_wr_cand;
    logic [1:0]        w_wr_gnt;
    logic [1:0]        w_rd_cand;
    logic [1:0]        w_rd_gnt;
    logic [ADDR_W-1:0] w_rd_cand_addr;
    logic              w_hazard;
    logic              w_valid_live;

    logic              r_rd_valid;
    cli_t              r_rd_owner;

    rr_arb2 u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({b_wr_req, a_wr_req}),
        .advance (|w_wr_gnt),
        .gnt     (w_wr_cand)
    );

    rr_arb2 u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({b_rd_req, a_rd_req}),
        .advance (|w_rd_gnt),
        .gnt     (w_rd_cand)
    );

    // Write side: grant the arbiter's pick and steer its address/data to the RAM
    always_comb begin
        w_wr_gnt    = rst ? 2'b00 : w_wr_cand;
        ram_wr_en   = |w_wr_gnt;
        ram_wr_addr = '0;
        ram_din     = '0;
        if (w_wr_gnt[1]) begin
            ram_wr_addr = b_wr_addr;
            ram_din     = b_wr_data;
        end else if (w_wr_gnt[0]) begin
            ram_wr_addr = a_wr_addr;
            ram_din     = a_wr_data;
        end
    end

    // Read side: withhold every read grant when the winner hits the write address
    always_comb begin
        w_rd_cand_addr = '0;
        if (w_rd_cand[1]) begin
            w_rd_cand_addr = b_rd_addr;
        end else if (w_rd_cand[0]) begin
            w_rd_cand_addr = a_rd_addr;
        end
        w_hazard    = (|w_rd_cand) && ram_wr_en && (w_rd_cand_addr == ram_wr_addr);
        w_rd_gnt    = (rst || w_hazard) ? 2'b00 : w_rd_cand;
        ram_rd_en   = |w_rd_gnt;
        ram_rd_addr = ram_rd_en ? w_rd_cand_addr : '0;
    end

    // Remember who issued the read so the returning data goes to that client
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_owner <= CLI_A;
        end else begin
            r_rd_valid <= ram_rd_en;
            if (ram_rd_en) begin
                r_rd_owner <= w_rd_gnt[1] ? CLI_B : CLI_A;
            end
        end
    end

    // Return data to the owner only; everything is quiet while in reset
    always_comb begin
        w_valid_live = r_rd_valid && !rst;
        a_wr_gnt     = w_wr_gnt[0];
        b_wr_gnt     = w_wr_gnt[1];
        a_rd_gnt     = w_rd_gnt[0];
        b_rd_gnt     = w_rd_gnt[1];
        a_rd_valid   = w_valid_live && (r_rd_owner == CLI_A);
        b_rd_valid   = w_valid_live && (r_rd_owner == CLI_B);
        a_rd_data    = a_rd_valid ? ram_dout : '0;
        b_rd_data    = b_rd_valid ? ram_dout : '0;
    end

endmodule : dpram_port_arbiter
`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_port_arbiter
// Description : Directed, table-driven bench for dpram_port_arbiter with a
//               behavioural RAM (registered read) attached to the RAM ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_wr_req, b_wr_req, a_rd_req, b_rd_req;
    logic [3:0] a_wr_addr, b_wr_addr, a_rd_addr, b_rd_addr;
    logic [7:0] a_wr_data, b_wr_data;
    logic       a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt;
    logic       a_rd_valid, b_rd_valid;
    logic [7:0] a_rd_data, b_rd_data;
    logic       ram_wr_en, ram_rd_en;
    logic [3:0] ram_wr_addr, ram_rd_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic [7:0] mem [16];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dpram_port_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_wr_req(a_wr_req), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data), .a_wr_gnt(a_wr_gnt),
        .b_wr_req(b_wr_req), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .b_wr_gnt(b_wr_gnt),
        .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr), .a_rd_gnt(a_rd_gnt),
        .a_rd_valid(a_rd_valid), .a_rd_data(a_rd_data),
        .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr), .b_rd_gnt(b_rd_gnt),
        .b_rd_valid(b_rd_valid), .b_rd_data(b_rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout)
    );

    // External RAM: synchronous write, registered read
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
        if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
    end

    typedef struct {
        logic       awr; logic [3:0] awa; logic [7:0] awd;
        logic       bwr; logic [3:0] bwa; logic [7:0] bwd;
        logic       ard; logic [3:0] ara;
        logic       brd; logic [3:0] bra;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs [$];

    // Packed output word: {awg,bwg,arg,brg, av,bv, we,re, waddr, din, raddr, adata, bdata}
    function automatic logic [39:0] ex(input logic [3:0] g, input logic [1:0] vl,
                                       input logic we, input logic re,
                                       input logic [3:0] wa, input logic [7:0] wd,
                                       input logic [3:0] ra, input logic [7:0] ad,
                                       input logic [7:0] bd);
        return {g, vl, we, re, wa, wd, ra, ad, bd};
    endfunction

    function automatic logic [39:0] act();
        return {a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt, a_rd_valid, b_rd_valid,
                ram_wr_en, ram_rd_en, ram_wr_addr, ram_din, ram_rd_addr, a_rd_data, b_rd_data};
    endfunction

    task automatic add(input logic awr, input logic [3:0] awa, input logic [7:0] awd,
                       input logic bwr, input logic [3:0] bwa, input logic [7:0] bwd,
                       input logic ard, input logic [3:0] ara,
                       input logic brd, input logic [3:0] bra, input logic [39:0] e);
        vec_t v;
        v = '{awr, awa, awd, bwr, bwa, bwd, ard, ara, brd, bra, e};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        a_wr_req = v.awr; a_wr_addr = v.awa; a_wr_data = v.awd;
        b_wr_req = v.bwr; b_wr_addr = v.bwa; b_wr_data = v.bwd;
        a_rd_req = v.ard; a_rd_addr = v.ara;
        b_rd_req = v.brd; b_rd_addr = v.bra;
    endtask

    task automatic check(input string name, input logic [39:0] a, input logic [39:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic idle_inputs();
        vec_t v;
        v = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0, 40'h0};
        drive(v);
    endtask

    initial begin
        vec_t v;
        int   pulses;

        // --- directed table (one row per clock after reset release) ---
        add(1,1,8'h10, 1,2,8'h20, 0,0, 0,0, ex(4'b1000,2'b00,1,0,4'h1,8'h10,4'h0,8'h00,8'h00));
        add(1,1,8'h10, 1,2,8'h20, 0,0, 0,0, ex(4'b0100,2'b00,1,0,4'h2,8'h20,4'h0,8'h00,8'h00));
        add(1,1,8'h10, 1,2,8'h20, 0,0, 0,0, ex(4'b1000,2'b00,1,0,4'h1,8'h10,4'h0,8'h00,8'h00));
        add(1,1,8'h10, 1,2,8'h20, 0,0, 0,0, ex(4'b0100,2'b00,1,0,4'h2,8'h20,4'h0,8'h00,8'h00));
        add(1,3,8'h5A, 0,0,8'h00, 0,0, 0,0, ex(4'b1000,2'b00,1,0,4'h3,8'h5A,4'h0,8'h00,8'h00));
        add(1,7,8'h11, 0,0,8'h00, 0,0, 0,0, ex(4'b1000,2'b00,1,0,4'h7,8'h11,4'h0,8'h00,8'h00));
        add(0,0,8'h00, 0,0,8'h00, 1,7, 0,0, ex(4'b0010,2'b00,0,1,4'h0,8'h00,4'h7,8'h00,8'h00));
        add(0,0,8'h00, 0,0,8'h00, 0,0, 0,0, ex(4'b0000,2'b10,0,0,4'h0,8'h00,4'h0,8'h11,8'h00));
        add(1,5,8'hC3, 0,0,8'h00, 0,0, 1,5, ex(4'b1000,2'b00,1,0,4'h5,8'hC3,4'h0,8'h00,8'h00));
        add(0,0,8'h00, 0,0,8'h00, 0,0, 1,5, ex(4'b0001,2'b00,0,1,4'h0,8'h00,4'h5,8'h00,8'h00));
        add(0,0,8'h00, 0,0,8'h00, 0,0, 0,0, ex(4'b0000,2'b01,0,0,4'h0,8'h00,4'h0,8'h00,8'hC3));
        add(0,0,8'h00, 0,0,8'h00, 1,1, 1,2, ex(4'b0010,2'b00,0,1,4'h0,8'h00,4'h1,8'h00,8'h00));
        add(0,0,8'h00, 0,0,8'h00, 1,3, 1,2, ex(4'b0001,2'b10,0,1,4'h0,8'h00,4'h2,8'h10,8'h00));
        add(0,0,8'h00, 0,0,8'h00, 0,0, 0,0, ex(4'b0000,2'b01,0,0,4'h0,8'h00,4'h0,8'h00,8'h20));
        add(1,4,8'h44, 0,0,8'h00, 1,4, 1,2, ex(4'b1000,2'b00,1,0,4'h4,8'h44,4'h0,8'h00,8'h00));
        add(0,0,8'h00, 0,0,8'h00, 1,4, 1,2, ex(4'b0010,2'b00,0,1,4'h0,8'h00,4'h4,8'h00,8'h00));
        add(0,0,8'h00, 0,0,8'h00, 0,0, 1,2, ex(4'b0001,2'b10,0,1,4'h0,8'h00,4'h2,8'h44,8'h00));
        add(0,0,8'h00, 0,0,8'h00, 0,0, 0,0, ex(4'b0000,2'b01,0,0,4'h0,8'h00,4'h0,8'h00,8'h20));

        // --- reset: everything low even with all requests high ---
        v = '{1'b1, 4'h1, 8'hFF, 1'b1, 4'h2, 8'hEE, 1'b1, 4'h3, 1'b1, 4'h4, 40'h0};
        drive(v);
        rst = 1'b1;
        @(negedge clk);
        check("reset_outputs_0", act(), 40'h0);
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs_1", act(), 40'h0);

        // --- table: first row lands in the first cycle with rst low ---
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("row%0d", i), act(), vecs[i].exp);
        end

        // --- B read granted, then reset asserted: no stale valid ---
        @(posedge clk); #1;
        v = '{1'b1, 4'h9, 8'h99, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 4'h3, 40'h0};
        drive(v);
        @(negedge clk);
        check("pre_reset_grant", act(), ex(4'b1001,2'b00,1,1,4'h9,8'h99,4'h3,8'h00,8'h00));
        @(posedge clk); #1;
        rst = 1'b1;
        v = '{1'b1, 4'hA, 8'hAA, 1'b1, 4'hB, 8'hBB, 1'b1, 4'h1, 1'b1, 4'h2, 40'h0};
        drive(v);
        @(negedge clk);
        check("mid_reset_0", act(), 40'h0);
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_1", act(), 40'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_contention", act(), ex(4'b1010,2'b00,1,1,4'hA,8'hAA,4'h1,8'h00,8'h00));

        // --- fill every address with data = address ---
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            idle_inputs();
            a_wr_req = 1'b1; a_wr_addr = 4'(k); a_wr_data = 8'(k);
            @(negedge clk);
            check($sformatf("fill%0d", k), {32'h0, a_wr_gnt, ram_wr_en, ram_wr_addr, ram_din[1:0]},
                  {32'h0, 1'b1, 1'b1, 4'(k), 2'(k)});
        end

        // --- alternate A/B reads back-to-back, one return per cycle ---
        pulses = 0;
        for (int k = 0; k <= 16; k++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (k < 16) begin
                if (k % 2 == 0) begin a_rd_req = 1'b1; a_rd_addr = 4'(k); end
                else            begin b_rd_req = 1'b1; b_rd_addr = 4'(k); end
            end
            @(negedge clk);
            if (k < 16) begin
                check($sformatf("sweep_gnt%0d", k), {34'h0, a_rd_gnt, b_rd_gnt, ram_rd_addr},
                      {34'h0, (k % 2 == 0), (k % 2 == 1), 4'(k)});
            end
            if (k > 0) begin
                logic [17:0] got, want;
                got  = {a_rd_valid, b_rd_valid, a_rd_data, b_rd_data};
                want = ((k - 1) % 2 == 0) ? {2'b10, 8'(k - 1), 8'h00} : {2'b01, 8'h00, 8'(k - 1)};
                check($sformatf("sweep_ret%0d", k - 1), {22'h0, got}, {22'h0, want});
                if (got === want) pulses++;
            end
        end
        check("sweep_pulse_count", 40'(pulses), 40'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dpram_port_arbiter
`default_nettype wire
